// File: rtl/timer_sched_if.sv
// timer_sched_if: bundles the requester handshake and the shared countdown
// datapath signals of timer_sched.
//   req[1:0]      requester level requests
//   len0, len1    requested intervals in ticks (0..15)
//   cancel[1:0]   per-requester abort
//   gnt[1:0]      one-hot grant, held for the whole service
//   done[1:0]     one-cycle completion pulse
//   busy          scheduler not idle
//   tmr_start/tmr_stop/tmr_reset   countdown datapath controls
//   tmr_counter   countdown value from the datapath
//   tmr_alarm     countdown alarm from the datapath
// slave  = scheduler side, master = requesters plus datapath side.
interface timer_sched_if;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] cancel;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       tmr_start;
    logic       tmr_stop;
    logic       tmr_reset;
    logic [3:0] tmr_counter;
    logic       tmr_alarm;

    modport slave (
        input  req, len0, len1, cancel, tmr_counter, tmr_alarm,
        output gnt, done, busy, tmr_start, tmr_stop, tmr_reset
    );

    modport master (
        output req, len0, len1, cancel, tmr_counter, tmr_alarm,
        input  gnt, done, busy, tmr_start, tmr_stop, tmr_reset
    );
endinterface

// File: rtl/timer_sched.sv
// timer_sched: two-requester round-robin scheduler that runs one interval
// at a time on a shared countdown datapath (reset loads 15, start
// decrements once per clock while above 0).
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous active-high reset
//   bus    timer_sched_if.slave: requester handshake + datapath controls
//
// state | meaning
// IDLE  | no service; grant the next requester when any req is set
// CLEAR | tmr_reset high, datapath reloads 15
// ARM   | all datapath controls low, counter settles at 15
// RUN   | decrement until counter == 15 - len (or alarm)
// FIN   | done pulse to the winner, tmr_stop pulse, then back to IDLE
module timer_sched (
    input  logic          clk,
    input  logic          reset,
    timer_sched_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CLEAR, ARM, RUN, FIN} state_t;

    state_t     state;
    logic       win;        // requester currently being served
    logic       prio;       // requester favoured when both ask
    logic [3:0] target;
    logic [1:0] gnt_q;
    logic [1:0] done_q;
    logic       busy_q;
    logic       start_q;
    logic       stop_q;
    logic       treset_q;

    logic       pick;
    logic       cancel_win;
    logic       abort;
    logic [3:0] cnt_after;

    always_comb begin
        pick = 1'b0;
        if (bus.req == 2'b11)
            pick = prio;
        else
            pick = bus.req[1];
    end

    assign cancel_win = win ? bus.cancel[1] : bus.cancel[0];
    assign abort      = cancel_win && (state == CLEAR || state == ARM || state == RUN);

    // start is registered, so it is decided from the count the datapath
    // will hold next cycle; otherwise one extra decrement would slip in.
    assign cnt_after = (start_q && bus.tmr_counter != 4'd0) ? bus.tmr_counter - 4'd1
                                                            : bus.tmr_counter;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            win      <= 1'b0;
            prio     <= 1'b0;
            target   <= 4'd15;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            treset_q <= 1'b1;
        end else begin
            done_q   <= 2'b00;
            stop_q   <= 1'b0;
            treset_q <= 1'b0;
            if (abort) begin
                start_q <= 1'b0;
                stop_q  <= 1'b1;
                gnt_q   <= 2'b00;
                busy_q  <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (|bus.req) begin
                            win      <= pick;
                            target   <= 4'd15 - (pick ? bus.len1 : bus.len0);
                            gnt_q    <= pick ? 2'b10 : 2'b01;
                            treset_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state    <= CLEAR;
                        end
                    end
                    CLEAR: state <= ARM;
                    ARM: begin
                        start_q <= (cnt_after != target);
                        state   <= RUN;
                    end
                    RUN: begin
                        if (bus.tmr_counter == target || bus.tmr_alarm) begin
                            start_q <= 1'b0;
                            stop_q  <= 1'b1;
                            done_q  <= gnt_q;
                            state   <= FIN;
                        end else begin
                            start_q <= (cnt_after != target);
                        end
                    end
                    FIN: begin
                        gnt_q  <= 2'b00;
                        busy_q <= 1'b0;
                        prio   <= ~win;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.tmr_start = start_q;
    assign bus.tmr_stop  = stop_q;
    assign bus.tmr_reset = treset_q;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed bench for timer_sched with a behavioural model of
// the shared countdown datapath.
module tb_timer_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] cnt = 4'd0;
    int checks = 0;
    int errors = 0;

    timer_sched_if bus ();

    timer_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // datapath: tmr_reset loads 15, tmr_start decrements while above 0
    always @(posedge clk) begin
        if (bus.tmr_reset)
            cnt <= 4'd15;
        else if (bus.tmr_start && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end
    assign bus.tmr_counter = cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req       = 2'b00;
        bus.cancel    = 2'b00;
        bus.tmr_alarm = 1'b0;
        bus.len0      = 4'd0;
        bus.len1      = 4'd0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        reset = 1'b1;
        bus.req = 2'b11;
        bus.cancel = 2'b00;
        bus.tmr_alarm = 1'b0;
        bus.len0 = 4'd3;
        bus.len1 = 4'd3;
        tick();
        obs = {bus.gnt, bus.done, bus.busy, bus.tmr_start, bus.tmr_stop, bus.tmr_reset};
        checks++;
        if (obs !== 9'b00_00_0_0_0_1) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", obs, 9'b00_00_0_0_0_1);
        end
        tick();
        checks++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority gnt=%b busy=%b exp gnt=00 busy=0", bus.gnt, bus.busy);
        end
        bus.req = 2'b00;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.tmr_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_release tmr_reset=%b exp 0", bus.tmr_reset);
        end
    endtask

    task automatic test_single();
        int k = 0;
        int n = 0;
        logic [6:0] obs;
        do_reset();
        bus.req = 2'b01;
        bus.len0 = 4'd3;
        tick();
        obs = {bus.gnt, bus.done, bus.busy, bus.tmr_reset, bus.tmr_start};
        checks++;
        if (obs !== 7'b01_00_1_1_0) begin
            errors++;
            $display("FAIL single_clear got %b exp %b", obs, 7'b01_00_1_1_0);
        end
        tick();
        checks++;
        if ({bus.tmr_start, bus.tmr_stop, bus.tmr_reset} !== 3'b000 || cnt !== 4'd15) begin
            errors++;
            $display("FAIL single_arm ctl=%b cnt=%0d exp ctl=000 cnt=15",
                     {bus.tmr_start, bus.tmr_stop, bus.tmr_reset}, cnt);
        end
        tick();
        while (bus.done == 2'b00 && k < 20) begin
            if (bus.tmr_start) n++;
            tick();
            k++;
        end
        checks++;
        if (bus.done !== 2'b01 || bus.tmr_stop !== 1'b1) begin
            errors++;
            $display("FAIL single_done done=%b stop=%b exp done=01 stop=1", bus.done, bus.tmr_stop);
        end
        checks++;
        if (n != 3 || k != 4 || cnt !== 4'd12) begin
            errors++;
            $display("FAIL single_timing starts=%0d run=%0d cnt=%0d exp 3 4 12", n, k, cnt);
        end
        bus.req = 2'b00;
        tick();
        checks++;
        if ({bus.gnt, bus.done, bus.busy} !== 5'b00_00_0) begin
            errors++;
            $display("FAIL single_idle got %b exp 00000", {bus.gnt, bus.done, bus.busy});
        end
    endtask

    task automatic test_round_robin();
        int k = 0;
        do_reset();
        bus.req = 2'b11;
        bus.len0 = 4'd1;
        bus.len1 = 4'd2;
        tick();
        checks++;
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL rr_first_gnt got %b exp 01", bus.gnt);
        end
        while (bus.done == 2'b00 && k < 20) begin tick(); k++; end
        checks++;
        if (bus.done !== 2'b01 || cnt !== 4'd14) begin
            errors++;
            $display("FAIL rr_first_done done=%b cnt=%0d exp 01 14", bus.done, cnt);
        end
        tick();
        checks++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_gap gnt=%b busy=%b exp 00 0", bus.gnt, bus.busy);
        end
        tick();
        checks++;
        if (bus.gnt !== 2'b10) begin
            errors++;
            $display("FAIL rr_second_gnt got %b exp 10", bus.gnt);
        end
        k = 0;
        while (bus.done == 2'b00 && k < 20) begin tick(); k++; end
        checks++;
        if (bus.done !== 2'b10 || cnt !== 4'd13) begin
            errors++;
            $display("FAIL rr_second_done done=%b cnt=%0d exp 10 13", bus.done, cnt);
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_len_zero();
        logic seen = 1'b0;
        do_reset();
        bus.req = 2'b10;
        bus.len1 = 4'd0;
        tick();
        if (bus.tmr_start) seen = 1'b1;
        checks++;
        if (bus.gnt !== 2'b10) begin
            errors++;
            $display("FAIL len0_gnt got %b exp 10", bus.gnt);
        end
        tick();
        if (bus.tmr_start) seen = 1'b1;
        tick();
        if (bus.tmr_start) seen = 1'b1;
        checks++;
        if (bus.done !== 2'b00) begin
            errors++;
            $display("FAIL len0_early_done got %b exp 00", bus.done);
        end
        tick();
        if (bus.tmr_start) seen = 1'b1;
        checks++;
        if (bus.done !== 2'b10 || bus.tmr_stop !== 1'b1) begin
            errors++;
            $display("FAIL len0_done done=%b stop=%b exp 10 1", bus.done, bus.tmr_stop);
        end
        checks++;
        if (seen !== 1'b0 || cnt !== 4'd15) begin
            errors++;
            $display("FAIL len0_nostart seen=%b cnt=%0d exp 0 15", seen, cnt);
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_cancel();
        int n = 0;
        logic seen_done = 1'b0;
        do_reset();
        bus.req = 2'b01;
        bus.len0 = 4'd15;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (bus.tmr_start) n++;
            if (bus.done != 2'b00) seen_done = 1'b1;
            if (i < 4) tick();
        end
        checks++;
        if (n != 5 || cnt !== 4'd11) begin
            errors++;
            $display("FAIL cancel_run starts=%0d cnt=%0d exp 5 11", n, cnt);
        end
        bus.cancel = 2'b01;
        tick();
        if (bus.done != 2'b00) seen_done = 1'b1;
        checks++;
        if ({bus.gnt, bus.busy, bus.tmr_start, bus.tmr_stop} !== 5'b00_0_0_1 || seen_done) begin
            errors++;
            $display("FAIL cancel_abort got %b done_seen=%b exp 00001 0",
                     {bus.gnt, bus.busy, bus.tmr_start, bus.tmr_stop}, seen_done);
        end
        bus.cancel = 2'b00;
        bus.req = 2'b11;
        tick();
        checks++;
        if (bus.gnt !== 2'b01 || bus.tmr_stop !== 1'b0) begin
            errors++;
            $display("FAIL cancel_next_gnt gnt=%b stop=%b exp 01 0", bus.gnt, bus.tmr_stop);
        end
        bus.cancel = 2'b01;
        tick();
        checks++;
        if (bus.gnt !== 2'b00 || bus.tmr_stop !== 1'b1 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL cancel_in_clear gnt=%b stop=%b done=%b exp 00 1 00",
                     bus.gnt, bus.tmr_stop, bus.done);
        end
        bus.cancel = 2'b00;
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int k = 0;
        logic [8:0] obs;
        logic seen_done = 1'b0;
        do_reset();
        bus.req = 2'b01;
        bus.len0 = 4'd15;
        tick();
        tick();
        tick();
        while (cnt != 4'd9 && k < 20) begin tick(); k++; end
        checks++;
        if (cnt !== 4'd9 || bus.tmr_start !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reach cnt=%0d start=%b exp 9 1", cnt, bus.tmr_start);
        end
        reset = 1'b1;
        tick();
        obs = {bus.gnt, bus.done, bus.busy, bus.tmr_start, bus.tmr_stop, bus.tmr_reset};
        checks++;
        if (obs !== 9'b00_00_0_0_0_1) begin
            errors++;
            $display("FAIL midrun_reset got %b exp %b", obs, 9'b00_00_0_0_0_1);
        end
        reset = 1'b0;
        bus.req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done != 2'b00 || bus.gnt != 2'b00) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_after activity=%b exp 0", seen_done);
        end
    endtask

    task automatic test_len_change();
        int k = 0;
        do_reset();
        bus.req = 2'b01;
        bus.len0 = 4'd4;
        tick();
        tick();
        tick();
        tick();
        bus.len0 = 4'd9;
        bus.cancel = 2'b10;
        while (bus.done == 2'b00 && k < 20) begin tick(); k++; end
        checks++;
        if (bus.done !== 2'b01 || cnt !== 4'd11 || bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL lenchg_done done=%b cnt=%0d gnt=%b exp 01 11 01", bus.done, cnt, bus.gnt);
        end
        bus.cancel = 2'b00;
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_alarm();
        do_reset();
        bus.req = 2'b01;
        bus.len0 = 4'd10;
        tick();
        tick();
        tick();
        bus.req = 2'b00;
        tick();
        checks++;
        if (bus.gnt !== 2'b01 || bus.busy !== 1'b1 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL alarm_hold gnt=%b busy=%b done=%b exp 01 1 00", bus.gnt, bus.busy, bus.done);
        end
        bus.tmr_alarm = 1'b1;
        tick();
        bus.tmr_alarm = 1'b0;
        checks++;
        if (bus.done !== 2'b01 || bus.tmr_stop !== 1'b1 || bus.tmr_start !== 1'b0) begin
            errors++;
            $display("FAIL alarm_done done=%b stop=%b start=%b exp 01 1 0",
                     bus.done, bus.tmr_stop, bus.tmr_start);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL alarm_idle busy=%b done=%b exp 0 00", bus.busy, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_len_zero();
        test_cancel();
        test_reset_mid_run();
        test_len_change();
        test_alarm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
